vliw_issue_scoreboard: RTL and testbench
========================================

Name: vliw_issue_scoreboard

Overview:
Parametrised issue-control and writeback-tracking block for the VLIW core. It generalises the fixed per-slot latency delay lines into a configurable scoreboard.
- Accepts one bundle per cycle of NUM_LANES operations.
- Blocks issue on RAW, WAW and intra-bundle destination conflicts.
- Carries each destination register index down a per-lane latency pipe and emits writeback strobes.
- Sits between instruction decode and the functional-unit lanes; its wb outputs drive register-file write enables.

Parameters:
NUM_LANES, 6, number of functional-unit lanes per bundle
NUM_REGS, 32, architectural registers; register 0 is never tracked
REG_W, 5, register index width, equal to $clog2(NUM_REGS)
LAT_W, 8, width of each per-lane latency field
LANE_LAT, {8'd1,8'd1,8'd25,8'd4,8'd13,8'd4}, packed per-lane latency; lane i uses bits [i*LAT_W +: LAT_W]; each value must be between 1 and 255

Ports:
clk  in  1  clock
rst  in  1  reset
issue_valid  in  1  bundle presented
issue_ready  out  1  bundle accepted this cycle when issue_valid is also high (combinational)
issue_src_a  in  NUM_LANES*REG_W  first source register per lane
issue_src_b  in  NUM_LANES*REG_W  second source register per lane
issue_dst  in  NUM_LANES*REG_W  destination register per lane
issue_dst_en  in  NUM_LANES  lane writes a result
wb_valid  out  NUM_LANES  writeback strobe per lane (registered)
wb_reg  out  NUM_LANES*REG_W  writeback register index per lane (registered)
busy_mask  out  NUM_REGS  pending-write bit per register (registered)
inflight_cnt  out  $clog2(NUM_REGS+1)  population count of busy_mask (registered)

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: all pipe stages invalid; busy_mask=0; wb_valid=0; wb_reg=0; inflight_cnt=0. Reset mid-operation drops all in-flight entries and produces no wb strobes.
- Hazard evaluation:
  - A lane's dst is "enabled" when issue_dst_en[i]=1 and dst≠0.
  - RAW: any src_a or src_b in any lane, nonzero, with its busy bit set.
  - WAW: any enabled dst with its busy bit set.
  - Intra-bundle: two enabled lanes with the same dst.
  - issue_ready = !(RAW | WAW | intra-bundle). It is independent of issue_valid.
  - A source equal to a same-bundle dst is not a hazard; bundle reads see pre-bundle values.
- Acceptance (issue_valid & issue_ready at edge T), for each enabled lane i:
  - busy[dst] is set at edge T.
  - dst is pushed into lane i's pipe, whose depth is LANE_LAT[i].
  - wb_valid[i]=1 and wb_reg[i]=dst during the cycle after edge T+LANE_LAT[i]-1. Latency 1 means wb appears in the cycle immediately after acceptance.
- Non-enabled lanes push an invalid entry. While stalled, all pipes still advance with invalid entries.
- Clear: busy[wb_reg[i]] is cleared at the edge that ends the wb cycle.
- Same-edge set and clear of one register: set wins. This is reachable only with the optional feature.
- Pipes never collide: one entry enters each lane per cycle, so there is no structural stall.
- inflight_cnt equals the popcount of the next-state busy_mask, registered alongside it.
- Assertions (simulation only): LANE_LAT[i]≥1; NUM_REGS≤2**REG_W.

Optional Feature:
SCOREBOARD_BYPASS_EN
- Defined: a register whose wb_valid strobe is high this cycle is treated as not busy for RAW and WAW checks. This assumes the register file forwards write data to same-cycle reads. It saves one stall cycle per dependency.
- Undefined: busy bits hold through the wb cycle. A dependent bundle issues at the earliest in the cycle after wb.

Decomposition:
- Package vliw_pkg: NUM_LANES_DEF, REG_W_DEF, the lane index enum (LANE_ADD, LANE_MUL, LANE_FPA, LANE_FPM, LANE_LU, LANE_MEM), and the default latency constants.
- Sub-module lane_dst_pipe: a parametrised-depth valid+index shift register, one instance per lane. It replaces the fixed clockDelay lines.

Test Plan:
- Reset, then issue a bundle with lane0 dst=3 (latency 4) at cycle 0 → busy_mask[3]=1 from cycle 1; wb_valid[0]=1, wb_reg[0]=3 in cycle 4; busy_mask[3]=0 in cycle 5; inflight_cnt goes 0→1→0.
- RAW: lane3 (FPM, lat 25) dst=7, next bundle lane4 src_a=7 → issue_ready=0 for 25 cycles; without bypass it accepts in cycle 26, with bypass in cycle 25.
- WAW plus intra-bundle: lanes 0 and 4 both dst=9 → issue_ready=0 immediately. Lane0 dst=9 busy, then new lane1 dst=9 → stalled until busy clears.
- Register 0: all lanes dst=0 with dst_en=1 and src=0 → issue_ready=1, busy_mask stays 0, no wb_valid.
- Back-to-back independent bundles on all six lanes with distinct dsts each cycle → no stalls; wb order per lane matches issue order; inflight_cnt peaks at the sum of in-flight entries.
- Assert rst with 5 entries in flight → next cycle busy_mask=0, wb_valid=0; no strobes appear afterwards.

Source files
------------

// File: rtl/vliw_pkg.sv
// vliw_pkg: lane numbering and default lane latencies for the VLIW issue scoreboard
package vliw_pkg;
  localparam int NUM_LANES_DEF = 6;
  localparam int REG_W_DEF = 5;
  typedef enum logic [2:0] {LANE_ADD, LANE_MUL, LANE_FPA, LANE_FPM, LANE_LU, LANE_MEM} lane_e;
  localparam logic [7:0] LAT_ADD = 8'd4;
  localparam logic [7:0] LAT_MUL = 8'd13;
  localparam logic [7:0] LAT_FPA = 8'd4;
  localparam logic [7:0] LAT_FPM = 8'd25;
  localparam logic [7:0] LAT_LU = 8'd1;
  localparam logic [7:0] LAT_MEM = 8'd1;
  localparam logic [NUM_LANES_DEF*8-1:0] LANE_LAT_DEF = {LAT_MEM, LAT_LU, LAT_FPM, LAT_FPA, LAT_MUL, LAT_ADD};
endpackage

// File: rtl/lane_dst_pipe.sv
// lane_dst_pipe: DEPTH-stage valid+register-index delay line; the last stage is the lane's writeback register
module lane_dst_pipe #(
  parameter int DEPTH = 1,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [REG_W-1:0] in_reg,
  output logic             out_valid,
  output logic [REG_W-1:0] out_reg
);
  logic [DEPTH-1:0] v;
  logic [REG_W-1:0] r [DEPTH];
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) r[k] <= '0;
    end else begin
      v[0] <= in_valid;
      r[0] <= in_reg;
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= v[k-1];
        r[k] <= r[k-1];
      end
    end
  assign out_valid = v[DEPTH-1];
  assign out_reg = r[DEPTH-1];
endmodule

// File: rtl/vliw_issue_scoreboard.sv
// vliw_issue_scoreboard: RAW/WAW/intra-bundle issue gating, per-lane latency pipes and busy tracking.
// Define SCOREBOARD_BYPASS_EN to let a register in its writeback cycle count as free for hazard checks.
module vliw_issue_scoreboard
  import vliw_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int NUM_REGS = 32,
  parameter int REG_W = REG_W_DEF,
  parameter int LAT_W = 8,
  parameter logic [NUM_LANES*LAT_W-1:0] LANE_LAT = LANE_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [NUM_LANES*REG_W-1:0]    issue_src_a,
  input  logic [NUM_LANES*REG_W-1:0]    issue_src_b,
  input  logic [NUM_LANES*REG_W-1:0]    issue_dst,
  input  logic [NUM_LANES-1:0]          issue_dst_en,
  output logic [NUM_LANES-1:0]          wb_valid,
  output logic [NUM_LANES*REG_W-1:0]    wb_reg,
  output logic [NUM_REGS-1:0]           busy_mask,
  output logic [$clog2(NUM_REGS+1)-1:0] inflight_cnt
);
  localparam int CW = $clog2(NUM_REGS+1);
  logic [NUM_REGS-1:0] clr, set, busy_eff, busy_n;
  logic [NUM_LANES-1:0] dst_on, push;
  logic raw, waw, dup;
  logic [CW-1:0] cnt_n;
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (wb_valid[i]) clr[wb_reg[i*REG_W +: REG_W]] = 1'b1;
`ifdef SCOREBOARD_BYPASS_EN
    busy_eff = busy_mask & ~clr;
`else
    busy_eff = busy_mask;
`endif
    dst_on = '0;
    for (int i = 0; i < NUM_LANES; i++)
      dst_on[i] = issue_dst_en[i] && issue_dst[i*REG_W +: REG_W] != '0;
    raw = 1'b0;
    waw = 1'b0;
    dup = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      raw |= (issue_src_a[i*REG_W +: REG_W] != '0 && busy_eff[issue_src_a[i*REG_W +: REG_W]])
          || (issue_src_b[i*REG_W +: REG_W] != '0 && busy_eff[issue_src_b[i*REG_W +: REG_W]]);
      waw |= dst_on[i] && busy_eff[issue_dst[i*REG_W +: REG_W]];
      for (int j = 0; j < i; j++)
        dup |= dst_on[i] && dst_on[j] && issue_dst[i*REG_W +: REG_W] == issue_dst[j*REG_W +: REG_W];
    end
    issue_ready = !(raw || waw || dup);
    push = (issue_valid && issue_ready) ? dst_on : '0;
    set = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (push[i]) set[issue_dst[i*REG_W +: REG_W]] = 1'b1;
    // set after clear: a reissue in the writeback cycle keeps the register busy
    busy_n = (busy_mask & ~clr) | set;
    cnt_n = '0;
    for (int r = 0; r < NUM_REGS; r++) cnt_n = cnt_n + CW'(busy_n[r]);
  end
  always_ff @(posedge clk)
    if (rst) begin
      busy_mask <= '0;
      inflight_cnt <= '0;
    end else begin
      busy_mask <= busy_n;
      inflight_cnt <= cnt_n;
    end
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_dst_pipe #(.DEPTH(int'(LANE_LAT[g*LAT_W +: LAT_W])), .REG_W(REG_W)) u_pipe (
      .clk(clk),
      .rst(rst),
      .in_valid(push[g]),
      .in_reg(push[g] ? issue_dst[g*REG_W +: REG_W] : '0),
      .out_valid(wb_valid[g]),
      .out_reg(wb_reg[g*REG_W +: REG_W])
    );
  end
  always_ff @(posedge clk) begin
    assert (NUM_REGS <= 2**REG_W);
    for (int i = 0; i < NUM_LANES; i++) assert (LANE_LAT[i*LAT_W +: LAT_W] != '0);
  end
endmodule

// File: tb/tb_vliw_issue_scoreboard.sv
// tb_vliw_issue_scoreboard: table vectors, directed corner sequences and random bundles checked against an in-flight list model
module tb_vliw_issue_scoreboard;
  localparam int NL = 6;
  localparam int RW = 5;
  localparam int NR = 32;
  localparam int LAT [NL] = '{4, 13, 4, 25, 1, 1};
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, issue_valid, issue_ready;
  logic [NL*RW-1:0] issue_src_a, issue_src_b, issue_dst, wb_reg;
  logic [NL-1:0] issue_dst_en, wb_valid;
  logic [NR-1:0] busy_mask;
  logic [5:0] inflight_cnt;
  vliw_issue_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_src_a(issue_src_a), .issue_src_b(issue_src_b), .issue_dst(issue_dst),
    .issue_dst_en(issue_dst_en), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .busy_mask(busy_mask), .inflight_cnt(inflight_cnt)
  );
  always #5 clk = ~clk;
  typedef struct { int lane; int rg; int wbc; } ent_t;
  typedef struct { logic [NL*RW-1:0] sa, sb, d; logic [NL-1:0] en; bit rdy; } vec_t;
  ent_t q[$];
  vec_t tbl[12];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  bit acc;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [NL*RW-1:0] lv(int lane, int val);
    logic [NL*RW-1:0] v = '0;
    v[lane*RW +: RW] = RW'(val);
    return v;
  endfunction
  // a register is busy from the cycle after issue through its writeback cycle
  function automatic logic [NR-1:0] m_busy(bit byp);
    logic [NR-1:0] b = '0;
    foreach (q[k]) if (q[k].wbc >= cyc && !(byp && q[k].wbc == cyc)) b[q[k].rg] = 1'b1;
    return b;
  endfunction
  function automatic bit m_ready();
    logic [NR-1:0] b = m_busy(BYP);
    for (int i = 0; i < NL; i++) begin
      int a, s, d;
      a = int'(issue_src_a[i*RW +: RW]);
      s = int'(issue_src_b[i*RW +: RW]);
      d = int'(issue_dst[i*RW +: RW]);
      if ((a != 0 && b[a]) || (s != 0 && b[s])) return 1'b0;
      if (issue_dst_en[i] && d != 0) begin
        if (b[d]) return 1'b0;
        for (int j = 0; j < i; j++)
          if (issue_dst_en[j] && int'(issue_dst[j*RW +: RW]) == d) return 1'b0;
      end
    end
    return 1'b1;
  endfunction
  task automatic outs();
    logic [NR-1:0] eb;
    logic [NL-1:0] ev = '0;
    logic [NL*RW-1:0] er = '0;
    for (int k = q.size() - 1; k >= 0; k--) if (q[k].wbc < cyc) q.delete(k);
    eb = m_busy(1'b0);
    foreach (q[k]) if (q[k].wbc == cyc) begin
      ev[q[k].lane] = 1'b1;
      er[q[k].lane*RW +: RW] = RW'(q[k].rg);
    end
    chk("busy_mask", busy_mask, eb);
    chk("inflight_cnt", inflight_cnt, $countones(eb));
    chk("wb_valid", wb_valid, ev);
    for (int i = 0; i < NL; i++) if (ev[i]) chk("wb_reg", wb_reg[i*RW +: RW], er[i*RW +: RW]);
  endtask
  task automatic step();
    bit r;
    #1;
    r = m_ready();
    chk("issue_ready", issue_ready, r);
    acc = issue_valid && r && !rst;
    if (acc)
      for (int i = 0; i < NL; i++)
        if (issue_dst_en[i] && issue_dst[i*RW +: RW] != '0)
          q.push_back('{i, int'(issue_dst[i*RW +: RW]), cyc + LAT[i]});
    @(posedge clk);
    #1;
    cyc++;
    if (rst) q.delete();
    outs();
  endtask
  task automatic clr_in();
    issue_valid = 1'b0;
    issue_src_a = '0;
    issue_src_b = '0;
    issue_dst = '0;
    issue_dst_en = '0;
  endtask
  task automatic put(int lane, int a, int b, int d, bit en);
    issue_src_a[lane*RW +: RW] = RW'(a);
    issue_src_b[lane*RW +: RW] = RW'(b);
    issue_dst[lane*RW +: RW] = RW'(d);
    issue_dst_en[lane] = en;
  endtask
  task automatic drain();
    clr_in();
    repeat (30) step();
  endtask
  task automatic stall_count(output int n);
    n = 0;
    step();
    while (!acc && n < 60) begin
      n++;
      step();
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    int n;
    logic [NL-1:0] seen;
    tbl[0]  = '{'0, '0, '0, 6'b000000, 1'b1};
    tbl[1]  = '{lv(4, 7), '0, '0, 6'b000000, 1'b0};
    tbl[2]  = '{'0, lv(2, 12), '0, 6'b000000, 1'b0};
    tbl[3]  = '{'0, '0, lv(0, 7), 6'b000001, 1'b0};
    tbl[4]  = '{'0, '0, lv(0, 7), 6'b000000, 1'b1};
    tbl[5]  = '{'0, '0, lv(0, 9) | lv(4, 9), 6'b010001, 1'b0};
    tbl[6]  = '{'0, '0, lv(0, 9) | lv(4, 9), 6'b000001, 1'b1};
    tbl[7]  = '{'0, '0, '0, 6'b111111, 1'b1};
    tbl[8]  = '{lv(5, 9), '0, lv(0, 9), 6'b000001, 1'b1};
    tbl[9]  = '{lv(0, 1) | lv(1, 2), '0, lv(0, 5) | lv(1, 6), 6'b000011, 1'b1};
    tbl[10] = '{lv(3, 12), '0, '0, 6'b000000, 1'b0};
    tbl[11] = '{'0, '0, lv(5, 12), 6'b100000, 1'b0};
    clr_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    outs();
    chk("reset_wb_reg", wb_reg, '0);
    step();
    rst = 1'b0;
    // single lane0 writeback of r3 after 4 cycles
    put(0, 0, 0, 3, 1'b1);
    issue_valid = 1'b1;
    step();
    chk("a_busy_set", busy_mask, 32'h8);
    chk("a_cnt_one", inflight_cnt, 1);
    clr_in();
    repeat (3) step();
    chk("a_wb_valid", wb_valid, 6'b000001);
    chk("a_wb_reg", wb_reg[RW-1:0], 3);
    chk("a_busy_held", busy_mask, 32'h8);
    step();
    chk("a_busy_clr", busy_mask, 0);
    chk("a_cnt_zero", inflight_cnt, 0);
    // RAW behind the 25-cycle lane
    put(3, 0, 0, 7, 1'b1);
    issue_valid = 1'b1;
    step();
    clr_in();
    put(4, 7, 0, 0, 1'b0);
    issue_valid = 1'b1;
    stall_count(n);
    chk("raw_stalls", n, BYP ? 24 : 25);
    drain();
    // WAW on r9: lane0 in flight, lane1 waits
    put(0, 0, 0, 9, 1'b1);
    issue_valid = 1'b1;
    step();
    clr_in();
    put(1, 0, 0, 9, 1'b1);
    issue_valid = 1'b1;
    stall_count(n);
    chk("waw_stalls", n, BYP ? 3 : 4);
    drain();
    // hazard table probes with r7 and r12 held busy
    put(3, 0, 0, 7, 1'b1);
    put(1, 0, 0, 12, 1'b1);
    issue_valid = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      clr_in();
      issue_src_a = tbl[k].sa;
      issue_src_b = tbl[k].sb;
      issue_dst = tbl[k].d;
      issue_dst_en = tbl[k].en;
      #1;
      chk($sformatf("tbl%0d_ready", k), issue_ready, tbl[k].rdy);
      step();
    end
    drain();
    // register 0 is never tracked
    for (int i = 0; i < NL; i++) put(i, 0, 0, 0, 1'b1);
    issue_valid = 1'b1;
    #1;
    chk("reg0_ready", issue_ready, 1);
    seen = '0;
    step();
    clr_in();
    repeat (4) begin
      seen |= wb_valid;
      step();
    end
    chk("reg0_busy", busy_mask, 0);
    chk("reg0_wb", seen, 0);
    drain();
    // back-to-back independent full bundles
    for (int c = 0; c < 3; c++) begin
      clr_in();
      for (int i = 0; i < NL; i++) put(i, 0, 0, c * NL + i + 1, 1'b1);
      issue_valid = 1'b1;
      #1;
      chk("b2b_ready", issue_ready, 1);
      step();
    end
    chk("b2b_peak", inflight_cnt, 14);
    drain();
    // reset with five entries in flight
    for (int i = 0; i < 5; i++) put(i, 0, 0, 20 + i, 1'b1);
    issue_valid = 1'b1;
    step();
    clr_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", busy_mask, 0);
    chk("rst_wb", wb_valid, 0);
    seen = '0;
    repeat (30) begin
      step();
      seen |= wb_valid;
    end
    chk("rst_no_strobes", seen, 0);
    // random bundles
    for (int n2 = 0; n2 < 1500; n2++) begin
      clr_in();
      for (int i = 0; i < NL; i++)
        put(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0,
               int'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
      issue_valid = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
